// File: rtl/imem_fetch.sv
// imem_fetch: instruction RAM that clears itself after reset, with a loader write port and a stallable registered fetch.
// Build option: define IMEM_PARITY_EN to store an even-parity bit per word and flag corrupted fetches.
module imem_fetch #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] NOP        = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] pccounter,
  input  logic                  req,
  input  logic                  stall,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic [DATA_WIDTH-1:0] saidaInstrucao,
  output logic                  valid,
  output logic                  ready,
  output logic                  err
);

  localparam int unsigned           IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
`ifdef IMEM_PARITY_EN
  logic                    par_mem [DEPTH];
`endif

  logic                    mem_we;
  logic [IDX_W-1:0]        mem_widx;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [IDX_W-1:0]        rd_idx, wr_idx, clr_idx;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    rd_par_bad;
  logic                    fetch_in_range, wr_in_range, bypass;

  assign rd_idx         = pccounter[IDX_W-1:0];
  assign wr_idx         = prog_addr[IDX_W-1:0];
  assign clr_idx        = ptr_q[IDX_W-1:0];
  assign fetch_in_range = {1'b0, pccounter} < DEPTH_L;
  assign wr_in_range    = {1'b0, prog_addr} < DEPTH_L;
  assign bypass         = prog_we && wr_in_range && (prog_addr == pccounter);

  assign saidaInstrucao = instr_q;
  assign valid          = valid_q;
  assign err            = err_q;
  assign ready          = (state_q == RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = RUN;
          ptr_d   = '0;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    rd_word    = mem[rd_idx];
    rd_par_bad = 1'b0;
`ifdef IMEM_PARITY_EN
    rd_par_bad = par_mem[rd_idx] ^ (^rd_word);
`endif
  end

  always_comb begin
    instr_d   = instr_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = clr_idx;
    mem_wdata = NOP;
    if (state_q == CLEAR) begin
      mem_we  = 1'b1;
      valid_d = 1'b0;
    end else begin
      if (prog_we) begin
        if (wr_in_range) begin
          mem_we    = 1'b1;
          mem_widx  = wr_idx;
          mem_wdata = prog_data;
        end else begin
          err_d = 1'b1;
        end
      end
      if (!stall) begin
        if (req) begin
          valid_d = 1'b1;
          if (!fetch_in_range) begin
            instr_d = NOP;
            err_d   = 1'b1;
          end else if (bypass) begin
            // write-first: the word being written this edge wins over the stale array contents
            instr_d = prog_data;
          end else if (rd_par_bad) begin
            instr_d = NOP;
            err_d   = 1'b1;
          end else begin
            instr_d = rd_word;
          end
        end else begin
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
`ifdef IMEM_PARITY_EN
      par_mem[mem_widx] <= ^mem_wdata;
`endif
    end
  end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised instruction memory for the 8-bit processor's fetch stage. It replaces the fixed, preloaded instruction ROM with a configurable-width and configurable-depth RAM. The RAM clears itself after reset, accepts programming writes from a loader port, and serves PC-addressed fetches with a request/valid/stall handshake. It sits between the PC counter and the instruction decoder.

## Interface
- DATA_WIDTH, 8, instruction word width in bits
- ADDR_WIDTH, 8, PC and program-address width
- DEPTH, 256, number of words implemented; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH
- NOP, 0, word written during clear and returned on any invalid fetch

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- pccounter  in  ADDR_WIDTH  fetch address
- req  in  1  fetch request
- stall  in  1  decoder back-pressure; holds the current output
- prog_we  in  1  programming write enable
- prog_addr  in  ADDR_WIDTH  programming address
- prog_data  in  DATA_WIDTH  programming data
- saidaInstrucao  out  DATA_WIDTH  fetched instruction (registered)
- valid  out  1  saidaInstrucao holds a fresh fetch result
- ready  out  1  memory initialised and accepting fetches and writes
- err  out  1  one-cycle error pulse

## Operation
- Reset behaviour: reset_n low asynchronously forces the following values:
  - FSM = CLEAR, clear pointer = 0
  - saidaInstrucao = NOP
  - valid = 0, ready = 0, err = 0
- CLEAR state:
  - Each cycle writes NOP to mem[ptr], then increments ptr.
  - After the cycle that writes ptr = DEPTH-1, the FSM moves to RUN.
  - req and prog_we are ignored; valid stays 0.
- RUN state: ready = 1. There is no other transition out of RUN except reset.
- Fetch rules, in RUN (priority stall > req):
  - stall = 1: saidaInstrucao and valid hold their values; the request is not consumed.
  - stall = 0, req = 1, pccounter < DEPTH: next edge loads saidaInstrucao = mem[pccounter] and sets valid = 1.
  - stall = 0, req = 1, pccounter >= DEPTH: next edge loads saidaInstrucao = NOP, sets valid = 1 and pulses err.
  - stall = 0, req = 0: valid <= 0; saidaInstrucao holds.
- Programming writes, in RUN:
  - prog_we = 1 with prog_addr < DEPTH writes mem[prog_addr] at the edge.
  - prog_addr >= DEPTH: the write is dropped and err pulses.
- Simultaneous write and fetch to the same address, same cycle (not stalled): write-first; saidaInstrucao receives prog_data.
- A simultaneous range error from a fetch and from a write produces a single err pulse.
- Reset asserted mid-CLEAR or mid-RUN: the sequence restarts from ptr = 0. Prior memory contents are not guaranteed to survive reset.

## Timing
- Fetch latency is 1 cycle: a request sampled at edge N is visible after edge N.
- Throughput is one fetch per cycle while stall = 0.
- ready rises exactly DEPTH cycles after the first rising edge with reset_n high.
- err is high for exactly one cycle per offending event. It is registered and aligned with the associated valid for fetch errors.
- Write-to-read: a write at edge N is readable by a fetch sampled at edge N+1. It is also readable at edge N itself through the write-first bypass.
- The stall → hold relationship is combinational-to-register only: no output changes while stall = 1.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit computed on every write, including clear writes.
  - On a fetch, a parity mismatch returns NOP, sets valid = 1 and pulses err.
  - The test hook is internal only; no added ports.
- IMEM_PARITY_EN undefined:
  - No parity storage.
  - err reports only address-range violations.

## Test plan
- Reset/clear: DEPTH = 16. Release reset_n → ready = 0 for 16 cycles, then 1. A fetch of every address 0..15 returns 0x00.
- Program and fetch:
  - Write 0x27 to address 1 and 0x02 to address 2.
  - Assert req with pccounter = 1 then 2 on back-to-back cycles.
  - Required: saidaInstrucao = 0x27 then 0x02 on consecutive cycles, with valid = 1.
- Stall hold:
  - Fetch addr 1 (0x27), then assert stall for 3 cycles while pccounter = 2.
  - Required: output stays 0x27 with valid = 1. After stall drops, 0x02 appears one cycle later.
- Range error: DEPTH = 16.
  - Fetch pccounter = 20 → saidaInstrucao = 0x00, valid = 1, err for one cycle.
  - prog_we to address 18 → err pulses; memory is unchanged.
- Write-first collision: same cycle, prog_we addr 5 = 0xC8 and fetch addr 5 → output 0xC8.
- Mid-operation reset: drop reset_n during RUN → outputs return to reset values immediately; ready rises 16 cycles after release; address 1 reads 0x00. With IMEM_PARITY_EN, a forced parity flip on address 3 → fetch returns 0x00 and err pulses.
